// File: rtl/alu_reg_pipe_pkg.sv
// Shared constants for the pipelined register-file + ALU datapath:
// op codes carried in fs[4:2] and bit positions inside the 4-bit status word.
package alu_reg_pkg;
  localparam logic [2:0] FS_AND = 3'd0;
  localparam logic [2:0] FS_OR  = 3'd1;
  localparam logic [2:0] FS_ADD = 3'd2;
  localparam logic [2:0] FS_XOR = 3'd3;
  localparam logic [2:0] FS_LSL = 3'd4;
  localparam logic [2:0] FS_LSR = 3'd5;
  localparam logic [2:0] FS_ASR = 3'd6;
  localparam logic [2:0] FS_MOV = 3'd7;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;
endpackage

// File: rtl/alu_reg_pipe_if.sv
// Op-issue and result/status bundle between decoder, datapath and consumer.
// master = decoder/consumer side, slave = datapath side.
interface alu_reg_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [4:0]        fs;
  logic [DATA_W-1:0] k;
  logic              s;
  logic              w;
  logic              set_flags;
  logic              c0;
  logic [DATA_W-1:0] f;
  logic [3:0]        status;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_valid, addr_r, addr_a, addr_b, fs, k, s, w, set_flags, c0, out_ready,
    input  in_ready, f, status, out_valid
  );

  modport slave (
    input  in_valid, addr_r, addr_a, addr_b, fs, k, s, w, set_flags, c0, out_ready,
    output in_ready, f, status, out_valid
  );
endinterface

// File: rtl/alu_reg_pipe_alu_core.sv
// Combinational ALU: optional operand inversion, eight ops, NZCV flags.
// Shifts run on a one-bit-extended word so the last bit shifted out lands
// in the extension bit, which gives the carry with no data-dependent index.
module alu_core
  import alu_reg_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              c0_i,
  input  logic [4:0]        fs_i,
  output logic [DATA_W-1:0] res_o,
  output logic [3:0]        flags_o
);
  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] opa, opb;
  logic [SH_W-1:0]   sh;
  logic [DATA_W:0]   sum, lsl_ext, lsr_ext, asr_ext;
  logic              c, v;

  // Operand conditioning, op select and flag generation
  always_comb begin
    opa     = fs_i[1] ? ~a_i : a_i;
    opb     = fs_i[0] ? ~b_i : b_i;
    sh      = opb[SH_W-1:0];
    sum     = {1'b0, opa} + {1'b0, opb} + {{DATA_W{1'b0}}, c0_i};
    lsl_ext = {1'b0, opa} << sh;
    lsr_ext = {opa, 1'b0} >> sh;
    asr_ext = $unsigned($signed({opa, 1'b0}) >>> sh);
    res_o   = '0;
    c       = 1'b0;
    v       = 1'b0;
    case (fs_i[4:2])
      FS_AND: res_o = opa & opb;
      FS_OR:  res_o = opa | opb;
      FS_ADD: begin
        res_o = sum[DATA_W-1:0];
        c     = sum[DATA_W];
        v     = (opa[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != opa[DATA_W-1]);
      end
      FS_XOR: res_o = opa ^ opb;
      FS_LSL: begin
        res_o = lsl_ext[DATA_W-1:0];
        c     = lsl_ext[DATA_W];
      end
      FS_LSR: begin
        res_o = lsr_ext[DATA_W:1];
        c     = lsr_ext[0];
      end
      FS_ASR: begin
        res_o = asr_ext[DATA_W:1];
        c     = asr_ext[0];
      end
      default: res_o = opb;  // FS_MOV
    endcase
    flags_o        = '0;
    flags_o[FLG_Z] = (res_o == '0);
    flags_o[FLG_N] = res_o[DATA_W-1];
    flags_o[FLG_C] = c;
    flags_o[FLG_V] = v;
  end
endmodule

// File: rtl/alu_reg_pipe.sv
// Two-stage register-file + ALU pipeline. S1 holds resolved operands,
// S2 holds the ALU result; retirement (out_valid && out_ready) writes the
// register file and status. The top register reads as zero and is never
// written or forwarded.
module alu_reg_pipe
  import alu_reg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_N  = 32
) (
  input logic          clk,
  input logic          rst,
  alu_reg_pipe_if.slave bus
);
  localparam int ADDR_W = $clog2(REG_N);
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_N - 1);

  logic [DATA_W-1:0] rf_q [REG_N];
  logic [3:0]        status_q;

  logic              vld_p1_q, w_p1_q, sf_p1_q, c0_p1_q;
  logic [DATA_W-1:0] a_p1_q, b_p1_q;
  logic [4:0]        fs_p1_q;
  logic [ADDR_W-1:0] dst_p1_q;

  logic              vld_p2_q, w_p2_q, sf_p2_q;
  logic [DATA_W-1:0] f_p2_q;
  logic [3:0]        flg_p2_q;
  logic [ADDR_W-1:0] dst_p2_q;

  logic              retire, s1_adv, accept, hazard, in_ready;
  logic [DATA_W-1:0] a_d, b_d, alu_res;
  logic [3:0]        alu_flg;

  // True when addr names a register whose pending result is not yet readable
  function automatic logic pend_hit(input logic [ADDR_W-1:0] addr,
                                    input logic v1, input logic [ADDR_W-1:0] d1,
                                    input logic v2, input logic [ADDR_W-1:0] d2);
    return (addr != ZERO_REG) && ((v1 && d1 == addr) || (v2 && d2 == addr));
  endfunction

  // Operand read: hard zero, then retiring-result bypass, then register file
  function automatic logic [DATA_W-1:0] rd_opnd(input logic [ADDR_W-1:0] addr,
                                                input logic fwd_en,
                                                input logic [ADDR_W-1:0] fwd_addr,
                                                input logic [DATA_W-1:0] fwd_val,
                                                input logic [DATA_W-1:0] rf_val);
    if (addr == ZERO_REG) return '0;
    if (fwd_en && fwd_addr == addr) return fwd_val;
    return rf_val;
  endfunction

  // Handshake, interlock and operand resolution for the incoming op.
  // A stalled S2 result cannot be bypassed yet, so it interlocks as well.
  always_comb begin
    retire   = vld_p2_q && bus.out_ready;
    s1_adv   = vld_p1_q && (!vld_p2_q || retire);
    hazard   = pend_hit(bus.addr_a, vld_p1_q && w_p1_q, dst_p1_q,
                        vld_p2_q && w_p2_q && !retire, dst_p2_q) ||
               (!bus.s && pend_hit(bus.addr_b, vld_p1_q && w_p1_q, dst_p1_q,
                                   vld_p2_q && w_p2_q && !retire, dst_p2_q));
    in_ready = (!vld_p1_q || s1_adv) && !hazard;
    accept   = bus.in_valid && in_ready;
    a_d      = rd_opnd(bus.addr_a, retire && w_p2_q, dst_p2_q, f_p2_q, rf_q[bus.addr_a]);
    b_d      = bus.s ? bus.k
                     : rd_opnd(bus.addr_b, retire && w_p2_q, dst_p2_q, f_p2_q, rf_q[bus.addr_b]);
  end

  // ---- S1 -> S2 boundary: execute ----
  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a_i     (a_p1_q),
    .b_i     (b_p1_q),
    .c0_i    (c0_p1_q),
    .fs_i    (fs_p1_q),
    .res_o   (alu_res),
    .flags_o (alu_flg)
  );

  // S1: capture resolved operands on accept, empty when advancing
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1_q <= 1'b0;
      a_p1_q   <= '0;
      b_p1_q   <= '0;
      fs_p1_q  <= '0;
      c0_p1_q  <= 1'b0;
      w_p1_q   <= 1'b0;
      sf_p1_q  <= 1'b0;
      dst_p1_q <= '0;
    end else if (accept) begin
      vld_p1_q <= 1'b1;
      a_p1_q   <= a_d;
      b_p1_q   <= b_d;
      fs_p1_q  <= bus.fs;
      c0_p1_q  <= bus.c0;
      w_p1_q   <= bus.w;
      sf_p1_q  <= bus.set_flags;
      dst_p1_q <= bus.addr_r;
    end else if (s1_adv) begin
      vld_p1_q <= 1'b0;
    end
  end

  // S2: hold ALU result until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p2_q <= 1'b0;
      f_p2_q   <= '0;
      flg_p2_q <= '0;
      w_p2_q   <= 1'b0;
      sf_p2_q  <= 1'b0;
      dst_p2_q <= '0;
    end else if (s1_adv) begin
      vld_p2_q <= 1'b1;
      f_p2_q   <= alu_res;
      flg_p2_q <= alu_flg;
      w_p2_q   <= w_p1_q;
      sf_p2_q  <= sf_p1_q;
      dst_p2_q <= dst_p1_q;
    end else if (retire) begin
      vld_p2_q <= 1'b0;
    end
  end

  // ---- Retirement: architectural register file and status ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
      status_q <= '0;
    end else begin
      if (retire && w_p2_q && dst_p2_q != ZERO_REG) rf_q[dst_p2_q] <= f_p2_q;
      if (retire && sf_p2_q) status_q <= flg_p2_q;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.f         = f_p2_q;
  assign bus.status    = status_q;
  assign bus.out_valid = vld_p2_q;
endmodule

// File: tb/tb_alu_reg_pipe.sv
// Bench for alu_reg_pipe: directed scenarios plus randomized traffic. A
// sequential (one op at a time) reference model predicts every retired
// result and the status seen while that op waits in the output stage.
module tb_alu_reg_pipe;
  localparam int DW = 64;
  localparam logic [4:0] ZR = 5'd31;
  localparam logic [4:0] OP_AND = 5'b00000, OP_ADD = 5'b01000, OP_LSL = 5'b10000,
                         OP_ASR = 5'b11000, OP_MOV = 5'b11100;
  localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
  localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

  typedef struct packed { logic [DW-1:0] f; logic [3:0] st; } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic man_rdy, rand_bp, rnd_rdy;
  int   n_cmp = 0, n_err = 0;

  logic [DW-1:0] mreg [32];
  logic [3:0]    mstat;
  exp_t          exp_q [$];
  exp_t          e_mon;
  logic [DW-1:0] last_f, hold_f;
  logic          hold_v;

  alu_reg_pipe_if #(.DATA_W(DW), .ADDR_W(5)) bus ();
  alu_reg_pipe #(.DATA_W(DW), .REG_N(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.out_ready = rand_bp ? rnd_rdy : man_rdy;

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Reference ALU written from the op definitions
  function automatic void alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic c0, input logic [4:0] fs,
                                  output logic [DW-1:0] r, output logic [3:0] fl);
    logic [DW-1:0] oa, ob;
    logic [DW:0] us;
    logic signed [65:0] ss;
    int sh;
    logic c, v;
    oa = fs[1] ? ~a : a;
    ob = fs[0] ? ~b : b;
    sh = int'(ob[5:0]);
    c = 1'b0; v = 1'b0;
    case (fs[4:2])
      3'd0: r = oa & ob;
      3'd1: r = oa | ob;
      3'd2: begin
        us = {1'b0, oa} + {1'b0, ob} + {64'd0, c0};
        r  = us[DW-1:0];
        c  = us[DW];
        ss = $signed({{2{oa[DW-1]}}, oa}) + $signed({{2{ob[DW-1]}}, ob}) + $signed({65'd0, c0});
        v  = (ss > SMAX) || (ss < SMIN);
      end
      3'd3: r = oa ^ ob;
      3'd4: begin r = oa << sh; if (sh != 0) c = oa[DW - sh]; end
      3'd5: begin r = oa >> sh; if (sh != 0) c = oa[sh - 1]; end
      3'd6: begin r = $unsigned($signed(oa) >>> sh); if (sh != 0) c = oa[sh - 1]; end
      default: r = ob;
    endcase
    fl = {v, c, r[DW-1], (r == '0)};
  endfunction

  // Scoreboard: in-order retirement, result, prior status, stall stability
  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && bus.out_valid) begin
        n_cmp++;
        if (bus.f !== hold_f) begin
          n_err++;
          $display("FAIL stall_hold: f=%h required %h", bus.f, hold_f);
        end
      end
      hold_v = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_retire: f=%h with nothing outstanding", bus.f);
        end else begin
          e_mon = exp_q.pop_front();
          if (bus.f !== e_mon.f) begin
            n_err++;
            $display("FAIL retire_f: got %h required %h", bus.f, e_mon.f);
          end
          n_cmp++;
          if (bus.status !== e_mon.st) begin
            n_err++;
            $display("FAIL retire_status: got %b required %b", bus.status, e_mon.st);
          end
          last_f = bus.f;
        end
      end else if (bus.out_valid) begin
        hold_v = 1'b1;
        hold_f = bus.f;
      end
    end
  end

  task automatic drive_fields(input logic [4:0] ar, input logic [4:0] aa, input logic [4:0] ab,
                              input logic [4:0] fs, input logic [DW-1:0] kk, input logic ss,
                              input logic ww, input logic sf, input logic cc);
    bus.in_valid = 1'b1; bus.addr_r = ar; bus.addr_a = aa; bus.addr_b = ab; bus.fs = fs;
    bus.k = kk; bus.s = ss; bus.w = ww; bus.set_flags = sf; bus.c0 = cc;
  endtask

  task automatic wait_accept(output int stalls);
    logic acc;
    logic [DW-1:0] a, b, r;
    logic [3:0] fl;
    acc = 1'b0; stalls = 0;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1; else stalls++;
      @(posedge clk);
      if (acc) begin
        a = (bus.addr_a == ZR) ? '0 : mreg[bus.addr_a];
        b = bus.s ? bus.k : ((bus.addr_b == ZR) ? '0 : mreg[bus.addr_b]);
        alu_ref(a, b, bus.c0, bus.fs, r, fl);
        exp_q.push_back('{f: r, st: mstat});
        if (bus.w && bus.addr_r != ZR) mreg[bus.addr_r] = r;
        if (bus.set_flags) mstat = fl;
      end
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1 within 60 cycles", bus.in_ready);
    end
  endtask

  task automatic send_op(input logic [4:0] ar, input logic [4:0] aa, input logic [4:0] ab,
                         input logic [4:0] fs, input logic [DW-1:0] kk, input logic ss,
                         input logic ww, input logic sf, input logic cc, output int stalls);
    drive_fields(ar, aa, ab, fs, kk, ss, ww, sf, cc);
    wait_accept(stalls);
  endtask

  task automatic drain();
    rand_bp = 1'b0; man_rdy = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d ops outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_cmp++;
    if (bus.status !== mstat) begin
      n_err++;
      $display("FAIL drain_status: got %b required %b", bus.status, mstat);
    end
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    mstat = '0;
    exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL %s_out_valid: got %b required 0", tag, bus.out_valid); end
    n_cmp++;
    if (bus.status !== 4'b0000) begin n_err++; $display("FAIL %s_status: got %b required 0000", tag, bus.status); end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready: got %b required 1", tag, bus.in_ready); end
  endtask

  task automatic test_reset();
    int st;
    @(negedge clk);
    check_idle("powerup");
    @(posedge clk); #1;
    send_op(5'd9, ZR, ZR, OP_MOV, 64'h8000_0000_0000_0005, 1'b1, 1'b1, 1'b1, 1'b0, st);
    drain();
    man_rdy = 1'b0;
    send_op(5'd13, ZR, ZR, OP_MOV, 64'd77, 1'b1, 1'b1, 1'b1, 1'b0, st);
    send_op(5'd14, 5'd9, 5'd9, OP_ADD, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, st);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_idle("midreset");
    @(posedge clk); #1;
    man_rdy = 1'b1;
    for (int i = 0; i < 32; i++)
      send_op(5'd0, 5'(i), 5'(i), OP_MOV, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, st);
    drain();
  endtask

  task automatic test_add();
    int st;
    send_op(5'd0, ZR, ZR, OP_MOV, 64'd916, 1'b1, 1'b1, 1'b0, 1'b0, st);
    send_op(5'd1, ZR, ZR, OP_MOV, 64'd619, 1'b1, 1'b1, 1'b0, 1'b0, st);
    send_op(5'd20, 5'd0, 5'd1, OP_ADD, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, st);
    drain();
    n_cmp++;
    if (last_f !== 64'd1535) begin n_err++; $display("FAIL add_result: got %0d required 1535", last_f); end
    n_cmp++;
    if (bus.status !== 4'b0000) begin n_err++; $display("FAIL add_status: got %b required 0000", bus.status); end
  endtask

  task automatic test_logic_shift();
    int st;
    send_op(5'd3, ZR, ZR, OP_MOV, 64'h57, 1'b1, 1'b1, 1'b0, 1'b0, st);
    send_op(5'd5, ZR, ZR, OP_MOV, 64'd7, 1'b1, 1'b1, 1'b0, 1'b0, st);
    send_op(5'd21, 5'd3, 5'd5, OP_AND, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, st);
    drain();
    n_cmp++;
    if (last_f !== 64'd7) begin n_err++; $display("FAIL and_result: got %0d required 7", last_f); end
    send_op(5'd22, 5'd5, ZR, OP_LSL, 64'd3, 1'b1, 1'b1, 1'b1, 1'b0, st);
    drain();
    n_cmp++;
    if (last_f !== 64'd56 || bus.status !== 4'b0000) begin
      n_err++; $display("FAIL lsl_result: got %0d/%b required 56/0000", last_f, bus.status);
    end
    send_op(5'd9, ZR, ZR, OP_MOV, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, st);
    send_op(5'd23, 5'd9, ZR, OP_ASR, 64'd63, 1'b1, 1'b1, 1'b1, 1'b0, st);
    drain();
    n_cmp++;
    if (last_f !== 64'hFFFF_FFFF_FFFF_FFFF || bus.status !== 4'b0010) begin
      n_err++; $display("FAIL asr_result: got %h/%b required all-ones/0010", last_f, bus.status);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    send_op(5'd2, 5'd0, 5'd1, OP_ADD, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, st);
    n_cmp++;
    if (st != 0) begin n_err++; $display("FAIL raw_first_stalls: got %0d required 0", st); end
    send_op(5'd4, 5'd2, 5'd2, OP_ADD, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, st);
    n_cmp++;
    if (st != 1) begin n_err++; $display("FAIL raw_bubble: got %0d stall cycles required 1", st); end
    drain();
    n_cmp++;
    if (last_f !== 64'd3070) begin n_err++; $display("FAIL raw_result: got %0d required 3070", last_f); end
  endtask

  task automatic test_backpressure();
    int st1, st2, st3, lows;
    man_rdy = 1'b0;
    send_op(5'd10, ZR, ZR, OP_MOV, 64'd111, 1'b1, 1'b1, 1'b0, 1'b0, st1);
    send_op(5'd11, ZR, ZR, OP_MOV, 64'd222, 1'b1, 1'b1, 1'b0, 1'b0, st2);
    n_cmp++;
    if (st1 + st2 != 0) begin n_err++; $display("FAIL bp_first_accepts: got %0d stalls required 0", st1 + st2); end
    drive_fields(5'd12, ZR, ZR, OP_MOV, 64'd333, 1'b1, 1'b1, 1'b0, 1'b0);
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!bus.in_ready) lows++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (lows != 5) begin n_err++; $display("FAIL bp_in_ready_low: got %0d low cycles required 5", lows); end
    man_rdy = 1'b1;
    wait_accept(st3);
    drain();
    n_cmp++;
    if (last_f !== 64'd333) begin n_err++; $display("FAIL bp_last: got %0d required 333", last_f); end
  endtask

  task automatic test_zero_reg();
    int st;
    send_op(ZR, ZR, ZR, OP_MOV, 64'd55, 1'b1, 1'b1, 1'b0, 1'b0, st);
    send_op(5'd6, ZR, ZR, OP_ADD, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, st);
    drain();
    n_cmp++;
    if (last_f !== 64'd1) begin n_err++; $display("FAIL zero_reg: got %0d required 1", last_f); end
    send_op(5'd7, ZR, ZR, OP_MOV, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, st);
    send_op(5'd8, 5'd7, ZR, OP_ADD, 64'd1, 1'b1, 1'b1, 1'b1, 1'b0, st);
    drain();
    n_cmp++;
    if (last_f !== 64'd0 || bus.status !== 4'b0101) begin
      n_err++; $display("FAIL wrap_add: got %h/%b required 0/0101", last_f, bus.status);
    end
  endtask

  task automatic test_random();
    int st;
    logic [DW-1:0] kk;
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      kk = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 80));
      drive_fields(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom), kk, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      wait_accept(st);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();
  endtask

  initial begin
    rst = 1'b0; man_rdy = 1'b0; rand_bp = 1'b0; rnd_rdy = 1'b0;
    bus.in_valid = 1'b0; bus.addr_r = '0; bus.addr_a = '0; bus.addr_b = '0; bus.fs = '0;
    bus.k = '0; bus.s = 1'b0; bus.w = 1'b0; bus.set_flags = 1'b0; bus.c0 = 1'b0;
    last_f = '0; hold_f = '0; hold_v = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    test_reset();
    test_add();
    test_logic_shift();
    test_back_to_back();
    test_backpressure();
    test_zero_reg();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
